vitais_tamagotchi: RTL and testbench

//   Vital-signs tracker fed by the state controller's 4-bit estado.

---
 rtl/tamagotchi_pkg.sv | 15 +
 rtl/vitais_tamagotchi_gerador_tick.sv | 28 ++
 rtl/vitais_tamagotchi.sv | 150 +++++++++++++++
 tb/tb_vitais_tamagotchi.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tamagotchi_pkg.sv
// Controller state encoding for the tamagotchi. The state controller and the
// vital-signs tracker both import this package.
package tamagotchi_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    DORMINDO   = 4'd1,
    COMENDO    = 4'd2,
    DANDO_AULA = 4'd3,
    MORTO      = 4'd4
  } estado_t;

  localparam int ESTADO_W = 4;

endpackage

// File: rtl/vitais_tamagotchi_gerador_tick.sv
// Game-tick prescaler: counts 0..TICK_DIV-1 and wraps, asserting tick while
// the count sits at its last value.
module gerador_tick #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/vitais_tamagotchi.sv
// Vital-signs tracker: energia/saciedade/humor updated once per game tick.
// Optional macro VITAIS_GRACE_EN tolerates GRACE_TICKS consecutive zero ticks.
module vitais_tamagotchi
  import tamagotchi_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int NIVEL_W     = 7,
  parameter int MAX_NIVEL   = 100,
  parameter int GANHO       = 5,
  parameter int LIMIAR      = 20,
  parameter int GRACE_TICKS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         estado,
  output logic [NIVEL_W-1:0] energia,
  output logic [NIVEL_W-1:0] saciedade,
  output logic [NIVEL_W-1:0] humor,
  output logic               alerta,
  output logic               morreu,
  output logic               tick
);

  localparam int ARITH_W = NIVEL_W + 2;
  localparam logic signed [ARITH_W-1:0] MAX_S  = ARITH_W'(MAX_NIVEL);
  localparam logic signed [ARITH_W-1:0] GANHO_S = ARITH_W'(GANHO);
  localparam logic signed [ARITH_W-1:0] MENOS1 = -ARITH_W'(1);
  localparam logic signed [ARITH_W-1:0] MENOS2 = -ARITH_W'(2);
  localparam logic signed [ARITH_W-1:0] MAIS1  = ARITH_W'(1);
  localparam logic signed [ARITH_W-1:0] ZERO_S = '0;
  localparam logic [NIVEL_W-1:0] MAX_U    = NIVEL_W'(MAX_NIVEL);
  localparam logic [NIVEL_W-1:0] LIMIAR_U = NIVEL_W'(LIMIAR);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be >= 2");
  end
  if (MAX_NIVEL >= (1 << NIVEL_W)) begin : g_bad_max
    $error("MAX_NIVEL must fit in NIVEL_W bits");
  end
  if (GRACE_TICKS < 1) begin : g_bad_grace
    $error("GRACE_TICKS must be >= 1");
  end

  // Saturate a widened level delta back into [0, MAX_NIVEL].
  function automatic logic [NIVEL_W-1:0] clamp(input logic signed [ARITH_W-1:0] v);
    if (v < ZERO_S) return '0;
    if (v > MAX_S)  return MAX_U;
    return v[NIVEL_W-1:0];
  endfunction

  gerador_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_gerador_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  logic signed [ARITH_W-1:0] d_energia, d_saciedade, d_humor;
  logic [NIVEL_W-1:0] energia_nxt, saciedade_nxt, humor_nxt;
  logic frozen, any_zero, any_low, morreu_nxt, alerta_nxt;

  always_comb begin
    d_energia   = MENOS1;
    d_saciedade = MENOS1;
    d_humor     = MENOS1;
    case (estado)
      DORMINDO: begin
        d_energia   = GANHO_S;
        d_saciedade = MENOS1;
        d_humor     = ZERO_S;
      end
      COMENDO: begin
        d_energia   = MENOS1;
        d_saciedade = GANHO_S;
        d_humor     = MAIS1;
      end
      DANDO_AULA: begin
        d_energia   = MENOS2;
        d_saciedade = MENOS2;
        d_humor     = GANHO_S;
      end
      default: ;
    endcase
  end

  assign frozen = morreu | (estado == MORTO);

  always_comb begin
    energia_nxt   = energia;
    saciedade_nxt = saciedade;
    humor_nxt     = humor;
    if (!frozen) begin
      energia_nxt   = clamp($signed({2'b00, energia})   + d_energia);
      saciedade_nxt = clamp($signed({2'b00, saciedade}) + d_saciedade);
      humor_nxt     = clamp($signed({2'b00, humor})     + d_humor);
    end
  end

  assign any_zero = (energia_nxt == '0) | (saciedade_nxt == '0) | (humor_nxt == '0);
  assign any_low  = (energia_nxt < LIMIAR_U) | (saciedade_nxt < LIMIAR_U) |
                    (humor_nxt < LIMIAR_U);

`ifdef VITAIS_GRACE_EN
  localparam int ZC_W = (GRACE_TICKS > 0) ? $clog2(GRACE_TICKS + 1) : 1;
  localparam logic [ZC_W-1:0] GRACE_U = ZC_W'(GRACE_TICKS);

  logic [ZC_W-1:0] zero_cnt, zero_cnt_nxt;

  // A frozen tick (MORTO or already dead) neither advances nor clears the streak.
  always_comb begin
    zero_cnt_nxt = zero_cnt;
    if (!frozen) begin
      if (!any_zero)               zero_cnt_nxt = '0;
      else if (zero_cnt < GRACE_U) zero_cnt_nxt = zero_cnt + ZC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt <= '0;
    end else if (tick) begin
      zero_cnt <= zero_cnt_nxt;
    end
  end

  assign morreu_nxt = morreu | (!frozen & (zero_cnt_nxt == GRACE_U));
`else
  assign morreu_nxt = morreu | (!frozen & any_zero);
`endif

  assign alerta_nxt = any_low & ~morreu_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      energia   <= MAX_U;
      saciedade <= MAX_U;
      humor     <= MAX_U;
      alerta    <= 1'b0;
      morreu    <= 1'b0;
    end else if (tick) begin
      energia   <= energia_nxt;
      saciedade <= saciedade_nxt;
      humor     <= humor_nxt;
      alerta    <= alerta_nxt;
      morreu    <= morreu_nxt;
    end
  end

endmodule

// File: tb/tb_vitais_tamagotchi.sv
// Directed bench for vitais_tamagotchi with a 4-cycle game tick; expectations
// adapt to VITAIS_GRACE_EN when that macro is defined for the build.
module tb_vitais_tamagotchi;

  localparam int TD = 4;
`ifdef VITAIS_GRACE_EN
  localparam int GR = 3;
`else
  localparam int GR = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] estado;
  logic [6:0] energia, saciedade, humor;
  logic       alerta, morreu, tick;

  int passed = 0;
  int total  = 0;

  vitais_tamagotchi #(
    .TICK_DIV    (TD),
    .NIVEL_W     (7),
    .MAX_NIVEL   (100),
    .GANHO       (5),
    .LIMIAR      (20),
    .GRACE_TICKS (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .estado    (estado),
    .energia   (energia),
    .saciedade (saciedade),
    .humor     (humor),
    .alerta    (alerta),
    .morreu    (morreu),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_levels(input string tag, input int e, input int s, input int h);
    check({tag, "_energia"},   energia,   e);
    check({tag, "_saciedade"}, saciedade, s);
    check({tag, "_humor"},     humor,     h);
  endtask

  // Wait for the next tick pulse and return just after the edge that consumes it.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      @(negedge clk);
      while (tick !== 1'b1 && guard < 3 * TD) begin
        @(negedge clk);
        guard++;
      end
      if (tick !== 1'b1) begin
        total++;
        $error("FAIL tick_timeout: observed %b expected 1", tick);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #7;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    estado = 4'd0;
    #12;
    // 1: reset values and tick cadence
    check_levels("rst", 100, 100, 100);
    check("rst_morreu", morreu, 0);
    check("rst_alerta", alerta, 0);
    check("rst_tick",   tick,   0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("tick_c%0d", k), tick, (k % 4 == 3) ? 1 : 0);
    end
    check("two_idle_energia", energia, 98);

    // 2: IDLE down to 90, MORTO freezes, unknown code acts as IDLE
    run_ticks(8);
    check_levels("idle10", 90, 90, 90);
    check("idle10_alerta", alerta, 0);
    check("idle10_morreu", morreu, 0);
    estado = 4'd4;
    run_ticks(1);
    check_levels("morto", 90, 90, 90);
    estado = 4'd9;
    run_ticks(1);
    check_levels("code9", 89, 89, 89);

    // 3: saciedade clamps at the ceiling
    do_reset();
    estado = 4'd0;
    run_ticks(2);
    check("sac98", saciedade, 98);
    estado = 4'd2;
    run_ticks(1);
    check_levels("comendo", 97, 100, 99);

    // 4: energia and saciedade reach 0 under DANDO_AULA
    do_reset();
    estado = 4'd3;
    run_ticks(49);
    check_levels("aula49", 2, 2, 100);
    check("aula49_alerta", alerta, 1);
    check("aula49_morreu", morreu, 0);
    run_ticks(1);
    check_levels("aula50", 0, 0, 100);
    check("aula50_morreu", morreu, (GR == 1) ? 1 : 0);
    for (int k = 1; k < GR; k++) run_ticks(1);
    check("dead_morreu", morreu, 1);
    check("dead_alerta", alerta, 0);
    estado = 4'd0;
    run_ticks(2);
    check_levels("dead_idle", 0, 0, 100);
    check("dead_idle_morreu", morreu, 1);
    estado = 4'd1;
    run_ticks(1);
    check("dead_dormindo_energia", energia, 0);

    // 5: alerta follows the threshold; async reset mid-period
    do_reset();
    estado = 4'd3;
    run_ticks(40);
    check_levels("aula40", 20, 20, 100);
    check("aula40_alerta", alerta, 0);
    estado = 4'd2;
    run_ticks(1);
    check_levels("e19", 19, 25, 100);
    check("e19_alerta", alerta, 1);
    estado = 4'd1;
    run_ticks(1);
    check_levels("e24", 24, 24, 100);
    check("e24_alerta", alerta, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_levels("midrst", 100, 100, 100);
    check("midrst_tick", tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_tick_c2", tick, 0);
    @(negedge clk);
    check("midrst_tick_c3", tick, 1);

    // 6: only energia at zero, with and without grace
    do_reset();
    estado = 4'd3;
    run_ticks(49);
    estado = 4'd2;
    run_ticks(2);
    check_levels("ezero", 0, 12, 100);
    check("ezero_morreu", morreu, (GR == 1) ? 1 : 0);
`ifdef VITAIS_GRACE_EN
    check("ezero_alerta", alerta, 1);
    run_ticks(1);
    check_levels("ezero2", 0, 17, 100);
    check("ezero2_morreu", morreu, 0);
    estado = 4'd1;
    run_ticks(1);
    check_levels("recover", 5, 16, 100);
    check("recover_morreu", morreu, 0);
    estado = 4'd2;
    run_ticks(5);
    check_levels("zero_again", 0, 41, 100);
    check("zero_again_morreu", morreu, 0);
    run_ticks(1);
    check("zero_hold2_morreu", morreu, 0);
    run_ticks(1);
    check_levels("zero_hold3", 0, 51, 100);
    check("zero_hold3_morreu", morreu, 1);
    check("zero_hold3_alerta", alerta, 0);
`else
    check("ezero_alerta", alerta, 0);
    run_ticks(1);
    check_levels("ezero_frozen", 0, 12, 100);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
